// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder: request/response handshake,
// programmable wait states, RISC-V sized/signed loads and byte-lane stores.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddr,
  input  logic        ReqWrite,
  input  logic [2:0]  ReqStrobe,
  input  logic [31:0] ReqWData,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRData,
  output logic        RspError
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_write, r_err;
  logic [2:0]  r_strobe;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept, w_access, w_strobe_ok, w_misalign, w_oob, w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word, w_shift, w_load, w_wlane;
  logic [15:0]   w_half;
  logic [3:0]    w_be;

  // ReqReady is forced low while reset is held, independent of the state register
  assign ReqReady = RST && (r_state == S_IDLE);
  assign RspValid = (r_state == S_RESP);
  assign RspRData = r_rdata;
  assign RspError = r_err;
  assign w_accept = ReqValid && ReqReady;
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // Fault decode on the latched request; out-of-range words never touch storage
  always_comb begin
    w_strobe_ok = r_write ? (!r_strobe[2] && (r_strobe[1:0] != 2'b11))
                          : ((r_strobe[1:0] != 2'b11) && (r_strobe != 3'b110));
    w_misalign  = ((r_strobe[1:0] == 2'b01) && r_addr[0]) ||
                  ((r_strobe[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    w_oob       = {2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS);
    w_err       = !w_strobe_ok || w_misalign || w_oob;
    w_idx       = w_oob ? '0 : r_addr[AW+1:2];
  end

  // Load lane select + extension, and store lane replication/byte enables
  always_comb begin
    w_word  = r_mem[w_idx];
    w_shift = w_word >> {r_addr[1:0], 3'b000};
    w_half  = r_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load  = w_word;
    w_wlane = r_wdata;
    w_be    = 4'b1111;
    case (r_strobe[1:0])
      2'b00: begin
        w_load  = {{24{!r_strobe[2] && w_shift[7]}}, w_shift[7:0]};
        w_wlane = {4{r_wdata[7:0]}};
        w_be    = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        w_load  = {{16{!r_strobe[2] && w_half[15]}}, w_half};
        w_wlane = {2{r_wdata[15:0]}};
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (RspReady) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_strobe <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= ReqAddr;
        r_wdata  <= ReqWData;
        r_write  <= ReqWrite;
        r_strobe <= ReqStrobe;
        r_cnt    <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_write) ? 32'd0 : w_load;
      end else if (r_state == S_RESP && RspReady) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  // Storage is not reset; a write happens only on the access edge of a good store
  always_ff @(posedge CLK) begin
    if (w_access && r_write && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder with a byte-level reference model.
module tb_data_mem_responder;
  localparam int DEPTH = 64;
  localparam int WS    = 1;

  logic        CLK, RST, ReqValid, ReqReady, ReqWrite, RspValid, RspReady, RspError;
  logic [31:0] ReqAddr, ReqWData, RspRData;
  logic [2:0]  ReqStrobe;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RST(RST), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .ReqWrite(ReqWrite), .ReqStrobe(ReqStrobe), .ReqWData(ReqWData), .RspValid(RspValid),
    .RspReady(RspReady), .RspRData(RspRData), .RspError(RspError));

  typedef struct { logic [31:0] d; logic e; int acc; } exp_t;
  exp_t        q[$];
  logic [31:0] m [DEPTH];
  int          total = 0, bad = 0, cyc = 0, hold_left = 0;

  initial CLK = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: storage as words, accesses computed from size/offset arithmetic
  function automatic void model(input logic [31:0] a, input logic w, input logic [2:0] s,
                                input logic [31:0] d, output logic [31:0] r, output logic e);
    longint unsigned idx, off, sz, lm, v, mask;
    idx = a >> 2; off = a % 4; r = 0; e = 0;
    case (s)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (w && s > 3'd3) sz = 0;
    if (sz == 0 || (off % sz) != 0 || idx >= DEPTH) begin e = 1; return; end
    lm = (64'd1 << (8 * sz)) - 1;
    if (w) begin
      mask = lm << (8 * off);
      v = ({32'd0, m[idx]} & ~mask) | (({32'd0, d} << (8 * off)) & mask);
      m[idx] = v[31:0];
    end else begin
      v = ({32'd0, m[idx]} >> (8 * off)) & lm;
      if (s < 3'd4 && sz < 4 && v[8*sz-1]) v = v | (~lm);
      r = v[31:0];
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d,
                       input bit expect_rsp = 1, input bit k_use = 0,
                       input logic [31:0] k_d = '0, input logic k_e = 0);
    int t = 0;
    exp_t x;
    logic [31:0] r;
    logic e;
    @(negedge CLK);
    while (!ReqReady) begin
      @(negedge CLK);
      if (++t > 200) begin chk("req_timeout", 32'd0, 32'd1); return; end
    end
    ReqValid = 1; ReqAddr = a; ReqWrite = w; ReqStrobe = s; ReqWData = d;
    @(posedge CLK); #1;
    ReqValid = 0;
    if (expect_rsp) begin
      model(a, w, s, d, r, e);
      x.d = k_use ? k_d : r; x.e = k_use ? k_e : e; x.acc = cyc;
      q.push_back(x);
    end
  endtask

  // Monitor: pops on first sight of each response, then checks it stays stable
  always begin
    exp_t x, cur;
    bit   have;
    @(negedge CLK);
    if (!RST) begin have = 0; RspReady = 0; end
    else if (RspValid) begin
      if (!have) begin
        if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          x = q.pop_front(); cur = x; have = 1;
          chk("rdata", RspRData, x.d);
          chk("error", {31'd0, RspError}, {31'd0, x.e});
          chk("latency", cyc - x.acc, WS + 1);
        end
      end else begin
        chk("hold_rdata", RspRData, cur.d);
        chk("hold_error", {31'd0, RspError}, {31'd0, cur.e});
      end
      chk("ready_in_resp", {31'd0, ReqReady}, 32'd0);
      if (hold_left > 0) begin RspReady = 0; hold_left--; end
      else RspReady = ($urandom_range(0, 2) != 0);
      if (RspReady) have = 0;
    end else RspReady = 0;
  end

  initial begin
    int t;
    logic [31:0] a;
    RST = 0; ReqValid = 0; ReqAddr = 0; ReqWrite = 0; ReqStrobe = 0; ReqWData = 0; RspReady = 0;
    #1;
    chk("rst_ready", {31'd0, ReqReady}, 32'd0);
    chk("rst_valid", {31'd0, RspValid}, 32'd0);
    chk("rst_rdata", RspRData, 32'd0);
    chk("rst_error", {31'd0, RspError}, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1; #1;
    chk("post_rst_ready", {31'd0, ReqReady}, 32'd1);

    for (int i = 0; i < DEPTH; i++) issue(32'(i * 4), 1, 3'b010, $urandom);

    issue(32'h10, 1, 3'b010, 32'hDEADBEEF, 1, 1, 32'h0, 0);
    issue(32'h10, 0, 3'b010, 0, 1, 1, 32'hDEADBEEF, 0);
    issue(32'h13, 0, 3'b000, 0, 1, 1, 32'hFFFFFFDE, 0);
    issue(32'h13, 0, 3'b100, 0, 1, 1, 32'h000000DE, 0);
    issue(32'h12, 0, 3'b001, 0, 1, 1, 32'hFFFFDEAD, 0);
    issue(32'h10, 0, 3'b101, 0, 1, 1, 32'h0000BEEF, 0);
    issue(32'h11, 1, 3'b000, 32'h55, 1, 1, 32'h0, 0);
    issue(32'h10, 0, 3'b010, 0, 1, 1, 32'hDEAD55EF, 0);
    issue(32'h12, 0, 3'b010, 0, 1, 1, 32'h0, 1);
    issue(32'h11, 1, 3'b001, 32'hAAAA, 1, 1, 32'h0, 1);
    issue(32'h10, 0, 3'b011, 0, 1, 1, 32'h0, 1);
    issue(32'(DEPTH * 4), 0, 3'b010, 0, 1, 1, 32'h0, 1);
    issue(32'h10, 0, 3'b010, 0, 1, 1, 32'hDEAD55EF, 0);

    // Hold response for 5 cycles and pulse a request that must be ignored
    hold_left = 5;
    issue(32'h10, 0, 3'b010, 0);
    t = 0;
    while (!RspValid && t < 50) begin @(negedge CLK); t++; end
    if (!RspValid) chk("hold_wait_timeout", 32'd0, 32'd1);
    ReqValid = 1; ReqAddr = 32'h24; ReqWrite = 1; ReqStrobe = 3'b010; ReqWData = 32'hBAD0BAD0;
    @(negedge CLK);
    ReqValid = 0;

    // Reset during WAIT drops a store
    issue(32'h20, 1, 3'b010, 32'h12345678, 0);
    #2 RST = 0;
    #1;
    chk("wrst_ready", {31'd0, ReqReady}, 32'd0);
    chk("wrst_valid", {31'd0, RspValid}, 32'd0);
    chk("wrst_rdata", RspRData, 32'd0);
    chk("wrst_error", {31'd0, RspError}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1; #1;
    chk("wrst_release_ready", {31'd0, ReqReady}, 32'd1);
    chk("wrst_release_valid", {31'd0, RspValid}, 32'd0);
    issue(32'h20, 0, 3'b010, 0);

    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, DEPTH + 2) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) a = a | 32'h8000_0000;
      issue(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
    end

    t = 0;
    while ((q.size() != 0 || RspValid) && t < 1000) begin @(negedge CLK); t++; end
    repeat (5) @(negedge CLK);
    chk("drain", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, giving the extra access cycles per request (0..15).
REQ-003 SHALL use one clock, CLK; reset is asynchronous and active-low, port RST.
REQ-004 Ports SHALL be:
- CLK  in  1  clock, rising edge
- RST  in  1  async active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  responder accepts request
- ReqAddr  in  32  byte address
- ReqWrite  in  1  1=store, 0=load
- ReqStrobe  in  3  RISC-V funct3 size/sign code
- ReqWData  in  32  store data, right-aligned
- RspValid  out  1  response present
- RspReady  in  1  initiator accepts response
- RspRData  out  32  load data, extended
- RspError  out  1  access faulted

Function
REQ-005 SHALL implement FSM IDLE, WAIT, RESP.
REQ-006 ReqReady SHALL be 1 only in IDLE; a request is accepted on an edge with ReqValid=1 and ReqReady=1.
REQ-007 On accept, SHALL latch address, write, strobe and wdata, load wait counter with WAIT_STATES, and go to WAIT.
REQ-008 In WAIT, a counter value of 0 SHALL perform the access and go to RESP on that edge; otherwise the counter SHALL decrement.
REQ-009 RspValid SHALL rise exactly WAIT_STATES+1 edges after the accept edge.
REQ-010 In RESP, RspValid=1, and RspRData/RspError SHALL stay stable until an edge with RspReady=1, which SHALL return to IDLE.
REQ-011 Only one transaction SHALL be outstanding; ReqValid outside IDLE SHALL be ignored.
REQ-012 Valid load strobes SHALL be 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; valid store strobes SHALL be 000 SB, 001 SH, 010 SW.
REQ-013 Loads SHALL select the byte or half lane by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
REQ-014 Stores SHALL write only the addressed lanes, taking ReqWData[7:0] for SB and ReqWData[15:0] for SH; other bytes are unchanged.
REQ-015 Error SHALL be set for any of:
- invalid strobe for the direction
- halfword with addr[0]=1
- word with addr[1:0]!=0
- word index addr[31:2] >= DEPTH_WORDS
REQ-016 On error: no storage write, RspRData=0, RspError=1.
REQ-017 A store response SHALL carry RspRData=0.
REQ-018 A store's effect SHALL be visible to any load accepted after that store's response.
REQ-019 Storage word index SHALL be addr[31:2]; there is no wrap-around, and out-of-range accesses fault per REQ-015.

Reset
REQ-020 RST=0 SHALL immediately force:
- state IDLE, counter 0
- ReqReady=1 while RST=1 and in IDLE; ReqReady=0 while RST=0
- RspValid=0, RspRData=0, RspError=0
REQ-021 Reset during WAIT SHALL drop the request; a store not yet performed SHALL NOT modify storage.
REQ-022 Reset during RESP SHALL drop the response.
REQ-023 Storage contents SHALL NOT be altered by reset.

Verification
REQ-024 WAIT_STATES=1; SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> RspValid 2 edges after each accept, load RspRData=0xDEADBEEF, RspError=0.
REQ-025 After REQ-024: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-026 SB addr 0x11 data 0x00000055, then LW 0x10 -> 0xDEAD55EF.
REQ-027 Each of the following -> RspError=1, RspRData=0, storage unchanged:
- LW 0x12
- SH 0x11
- strobe 011
- LW at DEPTH_WORDS*4
REQ-028 Hold RspReady=0 for 5 cycles in RESP -> RspValid and data stable and ReqReady=0 throughout; a ReqValid pulse meanwhile is not accepted.
REQ-029 SW 0x20 data 0x12345678, assert RST in WAIT, release -> outputs zero and ReqReady=1; LW 0x20 returns the prior contents.
